// File: rtl/pcpi_bridge_pkg.sv
// Types and constants shared by the PCPI nibble bridge
// transmit and receive paths.
package pcpi_bridge_pkg;

  localparam int NIBBLE_W    = 4;
  localparam int NIBBLES_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    RELEASE
  } nib_state_e;

endpackage

// File: rtl/pcpi_result_nibble_tx_if.sv
// Nibble pin bundle between the bridge and the off-chip host.
// Four-phase valid/ack handshake.
interface pcpi_result_nibble_tx_if;
  import pcpi_bridge_pkg::*;

  logic [NIBBLE_W-1:0] nib_data;
  logic                nib_valid;
  logic                nib_first;
  logic                nib_ack;

  modport master (
    output nib_data,
    output nib_valid,
    output nib_first,
    input  nib_ack
  );

  modport slave (
    input  nib_data,
    input  nib_valid,
    input  nib_first,
    output nib_ack
  );

endinterface

// File: rtl/pcpi_result_nibble_tx_sync_ff.sv
// Multi-stage synchronizer for asynchronous pin inputs,
// flops clear to 0 on reset.
module sync_ff #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] chain_q;
  logic [DEPTH-1:0][WIDTH-1:0] chain_d;

  always_comb begin
    chain_d    = chain_q;
    chain_d[0] = d;
    for (int i = 1; i < DEPTH; i++) begin
      chain_d[i] = chain_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) chain_q <= '0;
    else     chain_q <= chain_d;
  end

  assign q = chain_q[DEPTH-1];

endmodule

// File: rtl/pcpi_result_nibble_tx.sv
// PCPI result return path: captures pcpi_rd and streams it
// to the host as nibbles, LSB first, over a 4-phase handshake.
module pcpi_result_nibble_tx
  import pcpi_bridge_pkg::*;
#(
  parameter int NIBBLES     = NIBBLES_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pcpi_ready,
  input  logic                    pcpi_wr,
  input  logic [NIBBLE_W*NIBBLES-1:0] pcpi_rd,
  input  logic                    ovr_clr,
  pcpi_result_nibble_tx_if.master nib,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  localparam int DW = NIBBLE_W * NIBBLES;
  localparam int IW = $clog2(NIBBLES + 1);

  nib_state_e    state_q, state_d;
  logic [DW-1:0] buf_q, buf_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;
  logic          ack_s;
  logic          cap;

  sync_ff #(
    .DEPTH (SYNC_STAGES),
    .WIDTH (1)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (nib.nib_ack),
    .q   (ack_s)
  );

  assign cap = pcpi_ready & pcpi_wr;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    unique case (state_q)
      IDLE: begin
        if (cap) begin
          buf_d   = pcpi_rd;
          idx_d   = '0;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (ack_s) begin
          buf_d   = buf_q >> NIBBLE_W;
          idx_d   = idx_q + IW'(1);
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack_s) begin
          if (idx_q == IW'(NIBBLES)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = PRESENT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // a drop must stay visible even if cleared that cycle
    if (cap && state_q != IDLE) ovr_d = 1'b1;
    else if (ovr_clr)           ovr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign nib.nib_data  = buf_q[NIBBLE_W-1:0];
  assign nib.nib_valid = (state_q == PRESENT);
  assign nib.nib_first = (state_q == PRESENT) && (idx_q == '0);
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign overrun       = ovr_q;

endmodule
